// File: rtl/mercury_pkg.sv
// Shared types for the mercury core: register index width, opcode classes,
// decoded uop fields and the issue request record held in the issue slot.
package mercury_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ALU  = 2'd1,
    OP_BRU  = 2'd2,
    OP_LSU  = 2'd3
  } opcode_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] lsrc1;
    logic [REG_IDX_W-1:0] lsrc2;
    logic [REG_IDX_W-1:0] ldst;
  } uop_info_t;

  typedef struct packed {
    uop_info_t  uop;
    opcode_t    op;
    logic [1:0] src_en;
    logic       wen;
  } issue_req_t;

endpackage

// File: rtl/mercury_scoreboard.sv
// Busy scoreboard: one bit per architectural register marking a pending write.
// Lookups see a same-cycle writeback as already complete, so a dependent uop
// can issue in the writeback cycle. Register 0 is hardwired not-busy.
module mercury_scoreboard
  import mercury_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int IW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [IW-1:0]       set_idx,
  input  logic                clr_en,
  input  logic [IW-1:0]       clr_idx,
  input  logic [2:0][IW-1:0]  rd_idx,
  output logic [2:0]          rd_busy,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy vector: clear on writeback, then set on issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Effective-busy lookups with writeback bypass.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rd_busy[i] = busy_q[rd_idx[i]]
                 & ~(clr_en & (clr_idx == rd_idx[i]))
                 & (rd_idx[i] != '0);
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/mercury_issue_ctrl.sv
// In-order issue controller: single issue slot between decode and execute.
// A uop leaves the slot only once its sources and destination are free of
// pending writes. Hazard stall cycles are counted in a saturating counter.
module mercury_issue_ctrl
  import mercury_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int PERF_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  uop_info_t            dec_uop_i,
  input  opcode_t              dec_op_i,
  input  logic [1:0]           dec_src_en_i,
  input  logic                 dec_wen_i,
  output logic                 iss_valid_o,
  input  logic                 iss_ready_i,
  output uop_info_t            iss_uop_o,
  output opcode_t              iss_op_o,
  input  logic                 wb_valid_i,
  input  logic [REG_IDX_W-1:0] wb_ldst_i,
  output logic [NUM_REGS-1:0]  busy_o,
  output logic [PERF_W-1:0]    stall_cnt_o
);

  localparam logic [PERF_W-1:0] CNT_MAX = '1;

  issue_req_t              slot_q;
  logic                    slot_v_q;
  logic [PERF_W-1:0]       stall_q;
  logic [2:0]              rd_busy;
  logic [2:0][REG_IDX_W-1:0] rd_idx;
  logic                    hazard;
  logic                    iss_fire;
  logic                    dec_fire;
  logic                    sb_set;

  assign rd_idx = {slot_q.uop.ldst, slot_q.uop.lsrc2, slot_q.uop.lsrc1};

  assign hazard = (slot_q.src_en[0] & rd_busy[0])
                | (slot_q.src_en[1] & rd_busy[1])
                | (slot_q.wen       & rd_busy[2]);

  assign iss_valid_o = slot_v_q & ~hazard & ~flush_i;
  assign iss_fire    = iss_valid_o & iss_ready_i;
  assign dec_ready_o = (~slot_v_q | iss_fire) & ~flush_i;
  assign dec_fire    = dec_valid_i & dec_ready_o;
  assign sb_set      = iss_fire & slot_q.wen & (slot_q.uop.ldst != '0);

  mercury_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IW       (REG_IDX_W)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (sb_set),
    .set_idx (slot_q.uop.ldst),
    .clr_en  (wb_valid_i),
    .clr_idx (wb_ldst_i),
    .rd_idx  (rd_idx),
    .rd_busy (rd_busy),
    .busy    (busy_o)
  );

  // Issue slot: flush empties, decode refills, issue drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_q <= 1'b0;
      slot_q   <= '{uop: '0, op: OP_NONE, src_en: 2'b00, wen: 1'b0};
    end else if (flush_i) begin
      slot_v_q <= 1'b0;
    end else if (dec_fire) begin
      slot_v_q <= 1'b1;
      slot_q   <= '{uop: dec_uop_i, op: dec_op_i, src_en: dec_src_en_i, wen: dec_wen_i};
    end else if (iss_fire) begin
      slot_v_q <= 1'b0;
    end
  end

  // Saturating hazard-stall counter; backpressure alone is not a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (slot_v_q & hazard & ~flush_i & (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign iss_uop_o   = slot_q.uop;
  assign iss_op_o    = slot_q.op;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_mercury_issue_ctrl.sv
module tb_mercury_issue_ctrl;
  import mercury_pkg::*;

  typedef struct {
    bit        flush;
    bit        dv;
    uop_info_t uop;
    opcode_t   op;
    bit [1:0]  se;
    bit        wen;
    bit        ir;
    bit        wbv;
    bit [4:0]  wbl;
  } in_t;

  typedef struct {
    in_t in;
    bit  eiv;
    bit  edr;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush_i = 1'b0;
  logic            dec_valid_i = 1'b0;
  uop_info_t       dec_uop_i = '0;
  opcode_t         dec_op_i = OP_NONE;
  logic [1:0]      dec_src_en_i = 2'b00;
  logic            dec_wen_i = 1'b0;
  logic            iss_ready_i = 1'b0;
  logic            wb_valid_i = 1'b0;
  logic [4:0]      wb_ldst_i = '0;

  logic            dec_ready_o, iss_valid_o;
  uop_info_t       iss_uop_o;
  opcode_t         iss_op_o;
  logic [31:0]     busy_o;
  logic [15:0]     stall_cnt_o;

  logic            s_dec_ready, s_iss_valid;
  uop_info_t       s_iss_uop;
  opcode_t         s_iss_op;
  logic [31:0]     s_busy;
  logic [3:0]      s_stall;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit         m_slot_v;
  issue_req_t m_slot;
  bit         m_busy [32];
  int         m_stall;

  mercury_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .dec_valid_i(dec_valid_i),
    .dec_ready_o(dec_ready_o), .dec_uop_i(dec_uop_i), .dec_op_i(dec_op_i),
    .dec_src_en_i(dec_src_en_i), .dec_wen_i(dec_wen_i), .iss_valid_o(iss_valid_o),
    .iss_ready_i(iss_ready_i), .iss_uop_o(iss_uop_o), .iss_op_o(iss_op_o),
    .wb_valid_i(wb_valid_i), .wb_ldst_i(wb_ldst_i), .busy_o(busy_o),
    .stall_cnt_o(stall_cnt_o)
  );

  mercury_issue_ctrl #(.PERF_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .dec_valid_i(dec_valid_i),
    .dec_ready_o(s_dec_ready), .dec_uop_i(dec_uop_i), .dec_op_i(dec_op_i),
    .dec_src_en_i(dec_src_en_i), .dec_wen_i(dec_wen_i), .iss_valid_o(s_iss_valid),
    .iss_ready_i(iss_ready_i), .iss_uop_o(s_iss_uop), .iss_op_o(s_iss_op),
    .wb_valid_i(wb_valid_i), .wb_ldst_i(wb_ldst_i), .busy_o(s_busy),
    .stall_cnt_o(s_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t ii(bit dv, bit [4:0] s1, bit [4:0] s2, bit [4:0] d,
                             opcode_t op, bit [1:0] se, bit wen,
                             bit wbv = 0, bit [4:0] wbl = 0, bit ir = 1, bit flush = 0);
    in_t x;
    x.flush = flush; x.dv = dv; x.op = op; x.se = se; x.wen = wen;
    x.uop.lsrc1 = s1; x.uop.lsrc2 = s2; x.uop.ldst = d;
    x.ir = ir; x.wbv = wbv; x.wbl = wbl;
    return x;
  endfunction

  function automatic in_t idle(bit wbv = 0, bit [4:0] wbl = 0, bit ir = 1);
    return ii(0, 0, 0, 0, OP_NONE, 2'b00, 0, wbv, wbl, ir, 0);
  endfunction

  function automatic vec_t v(in_t x, bit eiv, bit edr);
    vec_t r;
    r.in = x; r.eiv = eiv; r.edr = edr;
    return r;
  endfunction

  function automatic bit pending(int r, in_t x);
    return (r != 0) && m_busy[r] && !(x.wbv && (x.wbl == r[4:0]));
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    for (int r = 0; r < 32; r++) b[r] = m_busy[r];
    return b;
  endfunction

  task automatic model_reset();
    m_slot_v = 0;
    m_slot   = '{uop: '0, op: OP_NONE, src_en: 2'b00, wen: 1'b0};
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
    m_stall  = 0;
  endtask

  // One clock: drive at edge+1, check at edge+2, advance model, return at next edge+1.
  task automatic cyc(in_t x, bit use_exp = 0, bit eiv = 0, bit edr = 0);
    bit haz, exp_iv, exp_dr, fire;
    flush_i = x.flush; dec_valid_i = x.dv; dec_uop_i = x.uop; dec_op_i = x.op;
    dec_src_en_i = x.se; dec_wen_i = x.wen; iss_ready_i = x.ir;
    wb_valid_i = x.wbv; wb_ldst_i = x.wbl;
    #1;
    haz = (m_slot.src_en[0] && pending(int'(m_slot.uop.lsrc1), x))
       || (m_slot.src_en[1] && pending(int'(m_slot.uop.lsrc2), x))
       || (m_slot.wen       && pending(int'(m_slot.uop.ldst),  x));
    exp_iv = m_slot_v && !haz && !x.flush;
    fire   = exp_iv && x.ir;
    exp_dr = !x.flush && (!m_slot_v || fire);
    chk("iss_valid", iss_valid_o, exp_iv);
    chk("dec_ready", dec_ready_o, exp_dr);
    chk("busy", busy_o, model_busy());
    chk("stall_cnt", stall_cnt_o, (m_stall > 65535) ? 65535 : m_stall);
    chk("sat_stall_cnt", s_stall, (m_stall > 15) ? 15 : m_stall);
    if (exp_iv) begin
      chk("iss_uop", iss_uop_o, m_slot.uop);
      chk("iss_op", iss_op_o, m_slot.op);
    end
    if (use_exp) begin
      chk("vec_iss_valid", iss_valid_o, eiv);
      chk("vec_dec_ready", dec_ready_o, edr);
    end
    // advance model
    if (m_slot_v && haz && !x.flush) m_stall++;
    if (x.wbv) m_busy[x.wbl] = 0;
    if (fire && m_slot.wen && m_slot.uop.ldst != 0) m_busy[m_slot.uop.ldst] = 1;
    if (x.flush) m_slot_v = 0;
    else if (x.dv && exp_dr) begin
      m_slot_v = 1;
      m_slot = '{uop: x.uop, op: x.op, src_en: x.se, wen: x.wen};
    end else if (fire) m_slot_v = 0;
    @(posedge clk); #1;
  endtask

  vec_t vecs [23];
  uop_info_t saved_uop;
  logic [15:0] saved_stall;

  initial begin
    // independent stream, RAW with bypass, WAW, x0 destination
    vecs[0]  = v(ii(1, 2, 3, 1, OP_ALU, 2'b11, 1), 0, 1);
    vecs[1]  = v(ii(1, 5, 6, 4, OP_ALU, 2'b11, 1), 1, 1);
    vecs[2]  = v(idle(), 1, 1);
    vecs[3]  = v(idle(), 0, 1);
    vecs[4]  = v(idle(1, 1), 0, 1);
    vecs[5]  = v(idle(1, 4), 0, 1);
    vecs[6]  = v(ii(1, 0, 0, 5, OP_LSU, 2'b01, 1), 0, 1);
    vecs[7]  = v(ii(1, 5, 0, 6, OP_ALU, 2'b11, 1), 1, 1);
    vecs[8]  = v(idle(), 0, 0);
    vecs[9]  = v(idle(), 0, 0);
    vecs[10] = v(idle(), 0, 0);
    vecs[11] = v(idle(1, 5), 1, 1);
    vecs[12] = v(idle(), 0, 1);
    vecs[13] = v(idle(1, 6), 0, 1);
    vecs[14] = v(ii(1, 1, 2, 7, OP_ALU, 2'b00, 1), 0, 1);
    vecs[15] = v(ii(1, 3, 4, 7, OP_ALU, 2'b00, 1), 1, 1);
    vecs[16] = v(idle(), 0, 0);
    vecs[17] = v(idle(1, 7), 1, 1);
    vecs[18] = v(idle(), 0, 1);
    vecs[19] = v(idle(1, 7), 0, 1);
    vecs[20] = v(ii(1, 0, 0, 0, OP_ALU, 2'b01, 1), 0, 1);
    vecs[21] = v(idle(), 1, 1);
    vecs[22] = v(idle(), 0, 1);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iss_valid", iss_valid_o, 1'b0);
    chk("rst_dec_ready", dec_ready_o, 1'b1);
    chk("rst_busy", busy_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset mid-stream with a full slot and x8 busy
    cyc(ii(1, 1, 2, 8, OP_ALU, 2'b00, 1));
    cyc(ii(1, 8, 0, 9, OP_ALU, 2'b01, 1));
    chk("pre_rst_busy", busy_o, 32'h0000_0100);
    cyc(idle(0, 0, 1));
    cyc(idle(0, 0, 1));
    flush_i = 0; dec_valid_i = 0; iss_ready_i = 1; wb_valid_i = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_iss_valid", iss_valid_o, 1'b0);
    chk("midrst_dec_ready", dec_ready_o, 1'b1);
    chk("midrst_iss_uop", iss_uop_o, 15'h0);
    chk("midrst_iss_op", iss_op_o, OP_NONE);
    chk("midrst_busy", busy_o, 32'h0);
    chk("midrst_stall", stall_cnt_o, 16'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(idle(1, 8));
    cyc(idle());

    for (int i = 0; i < 23; i++) begin
      if (i == 4)  chk("indep_busy", busy_o, 32'h0000_0012);
      if (i == 12) chk("raw_stall_cnt", stall_cnt_o, 16'd3);
      cyc(vecs[i].in, 1, vecs[i].eiv, vecs[i].edr);
    end
    chk("x0_busy_clear", busy_o[0], 1'b0);

    // flush with a full slot and a same-cycle decode offer
    cyc(ii(1, 0, 0, 11, OP_ALU, 2'b00, 1));
    cyc(ii(1, 11, 0, 12, OP_ALU, 2'b01, 1), 1, 1, 1);
    cyc(ii(1, 1, 1, 20, OP_ALU, 2'b00, 1, 0, 0, 1, 1), 1, 0, 0);
    chk("flush_busy_kept", busy_o[11], 1'b1);
    cyc(idle(), 1, 0, 1);
    cyc(idle(1, 11));

    // writeback and issue of the same register in one cycle
    cyc(ii(1, 0, 0, 9, OP_ALU, 2'b00, 1));
    cyc(ii(1, 0, 0, 9, OP_LSU, 2'b00, 1));
    cyc(idle(1, 9), 1, 1, 1);
    chk("wb_set_same_reg", busy_o[9], 1'b1);
    cyc(idle(1, 9));

    // backpressure for 5 cycles
    cyc(ii(1, 14, 15, 13, OP_BRU, 2'b11, 1));
    saved_uop = iss_uop_o;
    saved_stall = stall_cnt_o;
    repeat (5) cyc(ii(1, 2, 2, 3, OP_ALU, 2'b11, 1, 0, 0, 0), 1, 1, 0);
    chk("bp_uop_stable", iss_uop_o, saved_uop);
    chk("bp_stall_same", stall_cnt_o, saved_stall);
    cyc(idle(), 1, 1, 1);
    cyc(idle(1, 13));

    // long stall saturates the 4-bit counter
    cyc(ii(1, 0, 0, 12, OP_LSU, 2'b00, 1));
    cyc(ii(1, 12, 0, 14, OP_ALU, 2'b01, 1));
    repeat (20) cyc(idle());
    chk("sat_hold_15", s_stall, 4'd15);
    cyc(idle(1, 12), 1, 1, 1);
    cyc(idle(1, 14));

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_t x;
      x.flush = ($urandom_range(0, 19) == 0);
      x.dv    = ($urandom_range(0, 3) != 0);
      x.uop.lsrc1 = 5'($urandom_range(0, 7));
      x.uop.lsrc2 = 5'($urandom_range(0, 7));
      x.uop.ldst  = 5'($urandom_range(0, 7));
      x.op  = opcode_t'($urandom_range(0, 3));
      x.se  = 2'($urandom_range(0, 3));
      x.wen = ($urandom_range(0, 3) != 0);
      x.ir  = ($urandom_range(0, 3) != 0);
      x.wbv = ($urandom_range(0, 2) == 0);
      x.wbl = 5'($urandom_range(0, 7));
      cyc(x);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
